// File: rtl/snake_head_ctrl_if.sv
// Bundle between the move_input stage, the snake head controller and its consumers.
// The controller takes the slave side; whoever drives direction/start takes the master side.
interface snake_head_ctrl_if #(
    parameter int XW = 5,
    parameter int YW = 5
);
    logic [2:0]    dir_in;
    logic          start;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [2:0]    cur_dir;
    logic          step_pulse;
    logic          game_over;
    logic [1:0]    state;

    modport master (
        output dir_in, start,
        input  head_x, head_y, cur_dir, step_pulse, game_over, state
    );

    modport slave (
        input  dir_in, start,
        output head_x, head_y, cur_dir, step_pulse, game_over, state
    );
endinterface

// File: rtl/snake_head_ctrl.sv
// Snake head controller: advances the head one cell per game tick, filters reversals,
// and either wraps at the board edge or ends the game there.
module snake_head_ctrl #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int XW       = 5,
    parameter int YW       = 5,
    parameter int TICK_DIV = 25000000,
    parameter int CW       = 25,
    parameter int START_X  = 16,
    parameter int START_Y  = 12,
    parameter bit WRAP     = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    snake_head_ctrl_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_LEFT  = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_UP    = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_START  = XW'(START_X);
    localparam logic [YW-1:0] Y_START  = YW'(START_Y);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    function automatic logic [2:0] opposite_dir(input logic [2:0] d);
        logic [2:0] o;
        case (d)
            DIR_LEFT:  o = DIR_RIGHT;
            DIR_RIGHT: o = DIR_LEFT;
            DIR_UP:    o = DIR_DOWN;
            DIR_DOWN:  o = DIR_UP;
            default:   o = DIR_NONE;
        endcase
        return o;
    endfunction

    function automatic logic is_move_dir(input logic [2:0] d);
        return (d >= DIR_LEFT) && (d <= DIR_DOWN);
    endfunction

    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [XW-1:0] head_x_r;
    logic [YW-1:0] head_y_r;
    logic [2:0]    cur_dir_r;
    logic [2:0]    pend_dir_r;
    logic          step_pulse_r;
    logic          game_over_r;

    logic          tick_s;
    logic          accept_s;
    logic [XW-1:0] next_x_s;
    logic [YW-1:0] next_y_s;
    logic          off_board_s;

    // Tick detect and reversal filter; reversals are judged against the committed direction.
    always_comb begin
        tick_s   = (cnt_r == CNT_LAST);
        accept_s = is_move_dir(bus.dir_in) && (bus.dir_in != opposite_dir(cur_dir_r));
    end

    // Candidate next head position for the pending direction, with edge handling.
    always_comb begin
        next_x_s    = head_x_r;
        next_y_s    = head_y_r;
        off_board_s = 1'b0;
        case (pend_dir_r)
            DIR_LEFT: begin
                if (head_x_r == {XW{1'b0}}) begin
                    if (WRAP) begin
                        next_x_s = X_MAX;
                    end else begin
                        off_board_s = 1'b1;
                    end
                end else begin
                    next_x_s = head_x_r - XW'(1);
                end
            end
            DIR_RIGHT: begin
                if (head_x_r == X_MAX) begin
                    if (WRAP) begin
                        next_x_s = {XW{1'b0}};
                    end else begin
                        off_board_s = 1'b1;
                    end
                end else begin
                    next_x_s = head_x_r + XW'(1);
                end
            end
            DIR_UP: begin
                if (head_y_r == {YW{1'b0}}) begin
                    if (WRAP) begin
                        next_y_s = Y_MAX;
                    end else begin
                        off_board_s = 1'b1;
                    end
                end else begin
                    next_y_s = head_y_r - YW'(1);
                end
            end
            DIR_DOWN: begin
                if (head_y_r == Y_MAX) begin
                    if (WRAP) begin
                        next_y_s = {YW{1'b0}};
                    end else begin
                        off_board_s = 1'b1;
                    end
                end else begin
                    next_y_s = head_y_r + YW'(1);
                end
            end
            default: begin
                next_x_s    = head_x_r;
                next_y_s    = head_y_r;
                off_board_s = 1'b0;
            end
        endcase
    end

    // Game FSM, tick counter, head position and direction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            head_x_r     <= X_START;
            head_y_r     <= Y_START;
            cur_dir_r    <= DIR_RIGHT;
            pend_dir_r   <= DIR_RIGHT;
            step_pulse_r <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            step_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CW{1'b0}};
                    if (accept_s) begin
                        pend_dir_r <= bus.dir_in;
                    end
                    if (bus.start) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A direction accepted on the step edge only affects the following step.
                    if (accept_s) begin
                        pend_dir_r <= bus.dir_in;
                    end
                    if (tick_s) begin
                        cnt_r     <= {CW{1'b0}};
                        cur_dir_r <= pend_dir_r;
                        if (off_board_s) begin
                            state_r     <= ST_OVER;
                            game_over_r <= 1'b1;
                        end else begin
                            head_x_r     <= next_x_s;
                            head_y_r     <= next_y_s;
                            step_pulse_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_OVER: begin
                    if (bus.start) begin
                        state_r     <= ST_RUN;
                        cnt_r       <= {CW{1'b0}};
                        head_x_r    <= X_START;
                        head_y_r    <= Y_START;
                        cur_dir_r   <= DIR_RIGHT;
                        pend_dir_r  <= DIR_RIGHT;
                        game_over_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CW{1'b0}};
                    game_over_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.head_x     = head_x_r;
    assign bus.head_y     = head_y_r;
    assign bus.cur_dir    = cur_dir_r;
    assign bus.step_pulse = step_pulse_r;
    assign bus.game_over  = game_over_r;
    assign bus.state      = state_r;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench for snake_head_ctrl on an 8x8 board, TICK_DIV=4: a wrapping instance
// driven from a vector table and a non-wrapping instance driven by a hand sequence.
module tb_snake_head_ctrl;

    typedef struct {
        logic       rst;
        logic       st;
        logic [2:0] dir;
        logic [2:0] hx;
        logic [2:0] hy;
        logic [2:0] cd;
        logic       sp;
        logic       go;
        logic [1:0] state;
    } vec_t;

    logic clk;
    logic a_reset;
    logic b_reset;
    int   n_vec;
    int   n_err;
    vec_t vecs[$];

    snake_head_ctrl_if #(.XW(3), .YW(3)) aif ();
    snake_head_ctrl_if #(.XW(3), .YW(3)) bif ();

    snake_head_ctrl #(
        .GRID_W(8), .GRID_H(8), .XW(3), .YW(3), .TICK_DIV(4), .CW(3),
        .START_X(4), .START_Y(4), .WRAP(1'b1)
    ) dut_wrap (
        .clk   (clk),
        .reset (a_reset),
        .bus   (aif.slave)
    );

    snake_head_ctrl #(
        .GRID_W(8), .GRID_H(8), .XW(3), .YW(3), .TICK_DIV(4), .CW(3),
        .START_X(4), .START_Y(4), .WRAP(1'b0)
    ) dut_edge (
        .clk   (clk),
        .reset (b_reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int r, input int s, input int d, input int hx, input int hy,
                       input int cd, input int sp, input int go, input int st);
        vec_t v;
        v.rst   = 1'(r);
        v.st    = 1'(s);
        v.dir   = 3'(d);
        v.hx    = 3'(hx);
        v.hy    = 3'(hy);
        v.cd    = 3'(cd);
        v.sp    = 1'(sp);
        v.go    = 1'(go);
        v.state = 2'(st);
        vecs.push_back(v);
    endtask

    // got/want packed as {hx, hy, cur_dir, step_pulse, game_over, state}
    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got hx=%0d hy=%0d dir=%0d sp=%0d go=%0d st=%0d, want hx=%0d hy=%0d dir=%0d sp=%0d go=%0d st=%0d",
                     name, got[12:10], got[9:7], got[6:4], got[3], got[2], got[1:0],
                     want[12:10], want[9:7], want[6:4], want[3], want[2], want[1:0]);
        end
    endtask

    function automatic logic [12:0] pack_b();
        return {bif.head_x, bif.head_y, bif.cur_dir, bif.step_pulse, bif.game_over, bif.state};
    endfunction

    function automatic logic [12:0] exp_b(input int hx, input int hy, input int cd,
                                          input int sp, input int go, input int st);
        return {3'(hx), 3'(hy), 3'(cd), 1'(sp), 1'(go), 2'(st)};
    endfunction

    initial begin
        int prev;
        int waited;
        n_vec = 0;
        n_err = 0;
        a_reset = 1'b1;
        b_reset = 1'b1;
        aif.dir_in = 3'd0;
        aif.start  = 1'b0;
        bif.dir_in = 3'd0;
        bif.start  = 1'b0;

        // Straight run to the right with wrap; a start pulse mid-RUN is ignored.
        add(1, 0, 0, 4, 4, 2, 0, 0, 0);
        add(0, 1, 0, 4, 4, 2, 0, 0, 1);
        prev = 4;
        for (int i = 0; i < 5; i++) begin
            add(0, (i == 1) ? 1 : 0, 0, prev, 4, 2, 0, 0, 1);
            add(0, 0, 0, prev, 4, 2, 0, 0, 1);
            add(0, 0, 0, prev, 4, 2, 0, 0, 1);
            prev = (prev + 1) % 8;
            add(0, 0, 0, prev, 4, 2, 1, 0, 1);
        end
        // Turn up, then a rejected reversal to down.
        add(0, 0, 3, 1, 4, 2, 0, 0, 1);
        add(0, 0, 0, 1, 4, 2, 0, 0, 1);
        add(0, 0, 0, 1, 4, 2, 0, 0, 1);
        add(0, 0, 0, 1, 3, 3, 1, 0, 1);
        add(0, 0, 4, 1, 3, 3, 0, 0, 1);
        add(0, 0, 0, 1, 3, 3, 0, 0, 1);
        add(0, 0, 0, 1, 3, 3, 0, 0, 1);
        add(0, 0, 0, 1, 2, 3, 1, 0, 1);
        // Last accepted direction wins; invalid codes ignored; left wraps from x=0.
        add(0, 0, 3, 1, 2, 3, 0, 0, 1);
        add(0, 0, 1, 1, 2, 3, 0, 0, 1);
        add(0, 0, 5, 1, 2, 3, 0, 0, 1);
        add(0, 0, 7, 0, 2, 1, 1, 0, 1);
        add(0, 0, 0, 0, 2, 1, 0, 0, 1);
        add(0, 0, 0, 0, 2, 1, 0, 0, 1);
        add(0, 0, 0, 0, 2, 1, 0, 0, 1);
        add(0, 0, 0, 7, 2, 1, 1, 0, 1);
        // Direction arriving on the step edge applies to the following step only.
        add(0, 0, 0, 7, 2, 1, 0, 0, 1);
        add(0, 0, 0, 7, 2, 1, 0, 0, 1);
        add(0, 0, 0, 7, 2, 1, 0, 0, 1);
        add(0, 0, 3, 6, 2, 1, 1, 0, 1);
        add(0, 0, 0, 6, 2, 1, 0, 0, 1);
        add(0, 0, 0, 6, 2, 1, 0, 0, 1);
        add(0, 0, 0, 6, 2, 1, 0, 0, 1);
        add(0, 0, 0, 6, 1, 3, 1, 0, 1);
        // Reset mid-RUN at counter 2 with head (6,4); IDLE accepts a direction; counter restarts at 0.
        add(1, 0, 0, 4, 4, 2, 0, 0, 0);
        add(0, 1, 0, 4, 4, 2, 0, 0, 1);
        for (int k = 5; k <= 6; k++) begin
            add(0, 0, 0, k - 1, 4, 2, 0, 0, 1);
            add(0, 0, 0, k - 1, 4, 2, 0, 0, 1);
            add(0, 0, 0, k - 1, 4, 2, 0, 0, 1);
            add(0, 0, 0, k, 4, 2, 1, 0, 1);
        end
        add(0, 0, 0, 6, 4, 2, 0, 0, 1);
        add(0, 0, 0, 6, 4, 2, 0, 0, 1);
        add(1, 0, 0, 4, 4, 2, 0, 0, 0);
        add(0, 0, 4, 4, 4, 2, 0, 0, 0);
        add(0, 0, 0, 4, 4, 2, 0, 0, 0);
        add(0, 1, 0, 4, 4, 2, 0, 0, 1);
        add(0, 0, 0, 4, 4, 2, 0, 0, 1);
        add(0, 0, 0, 4, 4, 2, 0, 0, 1);
        add(0, 0, 0, 4, 4, 2, 0, 0, 1);
        add(0, 0, 0, 4, 5, 4, 1, 0, 1);

        foreach (vecs[i]) begin
            a_reset    = vecs[i].rst;
            aif.start  = vecs[i].st;
            aif.dir_in = vecs[i].dir;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                {aif.head_x, aif.head_y, aif.cur_dir, aif.step_pulse, aif.game_over, aif.state},
                {vecs[i].hx, vecs[i].hy, vecs[i].cd, vecs[i].sp, vecs[i].go, vecs[i].state});
        end

        // Non-wrapping board: run right into the edge, freeze in OVER, restart.
        b_reset = 1'b1;
        @(posedge clk); #1;
        chk("edge_reset", pack_b(), exp_b(4, 4, 2, 0, 0, 0));
        b_reset   = 1'b0;
        bif.start = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        chk("edge_start", pack_b(), exp_b(4, 4, 2, 0, 0, 1));
        for (int x = 5; x <= 7; x++) begin
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("edge_step_x%0d", x), pack_b(), exp_b(x, 4, 2, 1, 0, 1));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("edge_before_exit", pack_b(), exp_b(7, 4, 2, 0, 0, 1));
        @(posedge clk); #1;
        chk("edge_exit", pack_b(), exp_b(7, 4, 2, 0, 1, 2));
        bif.dir_in = 3'd3;
        repeat (5) @(posedge clk);
        #1;
        chk("edge_over_frozen", pack_b(), exp_b(7, 4, 2, 0, 1, 2));
        bif.start = 1'b1;
        @(posedge clk); #1;
        bif.start  = 1'b0;
        bif.dir_in = 3'd0;
        chk("edge_restart", pack_b(), exp_b(4, 4, 2, 0, 0, 1));
        waited = 0;
        while (bif.step_pulse !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("edge_restart_latency", {10'd0, 3'(waited)}, {10'd0, 3'd4});
        chk("edge_restart_step", pack_b(), exp_b(5, 4, 2, 1, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
